// File: rtl/alien_pkg.sv
// Shared types and constants for the alien march sequencing logic.
package alien_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARCH   = 2'd1,
        CLEARED = 2'd2,
        INVADED = 2'd3
    } march_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef logic [3:0] level_t;
    localparam level_t LEVEL_MAX = 4'd15;

endpackage

// File: rtl/formation_extent.sv
// Combinational bounding box and population of the live part of the formation.
module formation_extent #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 5,
    localparam int CW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int CNTW = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] alive_matrix,
    output logic [CW-1:0]                     lcol,
    output logic [CW-1:0]                     rcol,
    output logic [RW-1:0]                     brow,
    output logic [CNTW-1:0]                   count,
    output logic                              any
);

    logic [NUM_COLS-1:0] col_any;
    logic [NUM_ROWS-1:0] row_any;

    always_comb begin
        col_any = '0;
        row_any = '0;
        count   = '0;
        lcol    = '0;
        rcol    = '0;
        brow    = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (alive_matrix[r][c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
                count = count + CNTW'(alive_matrix[r][c]);
            end
        end
        // Scan downward so the last hit is the leftmost occupied column.
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (col_any[c]) lcol = CW'(c);
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_any[c]) rcol = CW'(c);
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_any[r]) brow = RW'(r);
        end
    end

    assign any = |row_any;

endmodule

// File: rtl/alien_march_controller.sv
// Formation march sequencer: step timing, edge reversal with descent,
// wave-clear / invasion detection and level counting.
module alien_march_controller
    import alien_pkg::*;
#(
    parameter int NUM_ROWS     = 3,
    parameter int NUM_COLS     = 5,
    parameter int START_X      = 100,
    parameter int START_Y      = 50,
    parameter int SPACING_X    = 64,
    parameter int SPACING_Y    = 32,
    parameter int ALIEN_W      = 32,
    parameter int ALIEN_H      = 24,
    parameter int SCREEN_LEFT  = 0,
    parameter int SCREEN_RIGHT = 640,
    parameter int STEP_X       = 8,
    parameter int STEP_Y       = 16,
    parameter int INVADE_Y     = 400,
    parameter int MIN_FRAMES   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_tick,
    input  logic                              start,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] alive_matrix,
    output logic signed [15:0]                offset_x,
    output logic signed [15:0]                offset_y,
    output logic                              direction,
    output logic                              step_pulse,
    output logic                              descend_pulse,
    output logic                              wave_cleared,
    output logic                              invaded,
    output level_t                            level,
    output logic [1:0]                        state
);

    localparam int CW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CNTW = $clog2(NUM_ROWS * NUM_COLS + 1);

    localparam logic signed [16:0] START_X_S      = 17'(START_X);
    localparam logic signed [16:0] START_Y_S      = 17'(START_Y);
    localparam logic signed [16:0] SPACING_X_S    = 17'(SPACING_X);
    localparam logic signed [16:0] SPACING_Y_S    = 17'(SPACING_Y);
    localparam logic signed [16:0] ALIEN_W_S      = 17'(ALIEN_W);
    localparam logic signed [16:0] ALIEN_H_S      = 17'(ALIEN_H);
    localparam logic signed [16:0] SCREEN_LEFT_S  = 17'(SCREEN_LEFT);
    localparam logic signed [16:0] SCREEN_RIGHT_S = 17'(SCREEN_RIGHT);
    localparam logic signed [16:0] STEP_X_S       = 17'(STEP_X);
    localparam logic signed [16:0] STEP_Y_S       = 17'(STEP_Y);
    localparam logic signed [16:0] INVADE_Y_S     = 17'(INVADE_Y);
    localparam logic signed [16:0] MIN_FRAMES_S   = 17'(MIN_FRAMES);
    localparam logic signed [15:0] STEP_X16       = 16'(STEP_X);
    localparam logic signed [15:0] STEP_Y16       = 16'(STEP_Y);

    function automatic level_t level_inc(input level_t lvl);
        return (lvl == LEVEL_MAX) ? lvl : lvl + 4'd1;
    endfunction

    logic [CW-1:0]   lcol;
    logic [CW-1:0]   rcol;
    logic [RW-1:0]   brow;
    logic [CNTW-1:0] count;
    logic            any;

    formation_extent #(
        .NUM_ROWS(NUM_ROWS),
        .NUM_COLS(NUM_COLS)
    ) u_extent (
        .alive_matrix(alive_matrix),
        .lcol        (lcol),
        .rcol        (rcol),
        .brow        (brow),
        .count       (count),
        .any         (any)
    );

    march_state_t       state_q;
    logic [15:0]        frame_cnt;
    logic signed [16:0] left_edge;
    logic signed [16:0] right_edge;
    logic signed [16:0] bottom_edge;
    logic signed [16:0] interval_raw;
    logic signed [16:0] interval;
    logic               boundary;
    logic               hit_edge;
    logic               invade_next;

    assign left_edge   = START_X_S + 17'(offset_x) + $signed(17'(lcol)) * SPACING_X_S;
    assign right_edge  = START_X_S + 17'(offset_x) + $signed(17'(rcol)) * SPACING_X_S + ALIEN_W_S;
    assign bottom_edge = START_Y_S + 17'(offset_y) + $signed(17'(brow)) * SPACING_Y_S + ALIEN_H_S;

    // Fewer survivors and higher levels shorten the interval, floored at MIN_FRAMES.
    assign interval_raw = MIN_FRAMES_S + $signed(17'(count)) - $signed(17'(level));
    assign interval     = (interval_raw < MIN_FRAMES_S) ? MIN_FRAMES_S : interval_raw;
    assign boundary     = ($signed({1'b0, frame_cnt}) + 17'sd1) >= interval;

    assign hit_edge    = (direction == DIR_RIGHT) ? ((right_edge + STEP_X_S) > SCREEN_RIGHT_S)
                                                  : ((left_edge - STEP_X_S) < SCREEN_LEFT_S);
    assign invade_next = (bottom_edge + STEP_Y_S) >= INVADE_Y_S;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frame_cnt     <= '0;
            offset_x      <= '0;
            offset_y      <= '0;
            direction     <= DIR_RIGHT;
            step_pulse    <= 1'b0;
            descend_pulse <= 1'b0;
            wave_cleared  <= 1'b0;
            invaded       <= 1'b0;
            level         <= '0;
        end else begin
            step_pulse    <= 1'b0;
            descend_pulse <= 1'b0;
            wave_cleared  <= 1'b0;
            case (state_q)
                IDLE, INVADED: begin
                    if (start) begin
                        state_q   <= MARCH;
                        frame_cnt <= '0;
                        offset_x  <= '0;
                        offset_y  <= '0;
                        direction <= DIR_RIGHT;
                        level     <= '0;
                        invaded   <= 1'b0;
                    end
                end
                CLEARED: begin
                    if (start) begin
                        state_q   <= MARCH;
                        frame_cnt <= '0;
                        offset_x  <= '0;
                        offset_y  <= '0;
                        direction <= DIR_RIGHT;
                    end
                end
                MARCH: begin
                    if (!any) begin
                        state_q      <= CLEARED;
                        wave_cleared <= 1'b1;
                        level        <= level_inc(level);
                    end else if (frame_tick) begin
                        if (boundary) begin
                            frame_cnt  <= '0;
                            step_pulse <= 1'b1;
                            if (hit_edge) begin
                                offset_y      <= offset_y + STEP_Y16;
                                direction     <= ~direction;
                                descend_pulse <= 1'b1;
                                if (invade_next) begin
                                    state_q <= INVADED;
                                    invaded <= 1'b1;
                                end
                            end else if (direction == DIR_RIGHT) begin
                                offset_x <= offset_x + STEP_X16;
                            end else begin
                                offset_x <= offset_x - STEP_X16;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alien_march_controller.sv
// Directed bench for alien_march_controller with a per-alien reference model.
module tb_alien_march_controller;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_tick = 1'b0;
    logic              start = 1'b0;
    logic [2:0][4:0]   alive_matrix = '1;
    logic signed [15:0] offset_x;
    logic signed [15:0] offset_y;
    logic              direction;
    logic              step_pulse;
    logic              descend_pulse;
    logic              wave_cleared;
    logic              invaded;
    logic [3:0]        level;
    logic [1:0]        state;

    always #5 clk = ~clk;

    alien_march_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .start        (start),
        .alive_matrix (alive_matrix),
        .offset_x     (offset_x),
        .offset_y     (offset_y),
        .direction    (direction),
        .step_pulse   (step_pulse),
        .descend_pulse(descend_pulse),
        .wave_cleared (wave_cleared),
        .invaded      (invaded),
        .level        (level),
        .state        (state)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modes 0 idle, 1 march, 2 cleared, 3 invaded.
    int m_mode = 0, m_ox = 0, m_oy = 0, m_dir = 1, m_cnt = 0, m_lvl = 0, m_inv = 0;
    int m_step = 0, m_desc = 0, m_clr = 0;

    always @(posedge clk or negedge rst_n) begin
        int n, lft, rgt, bot, ival;
        if (!rst_n) begin
            m_mode = 0; m_ox = 0; m_oy = 0; m_dir = 1; m_cnt = 0; m_lvl = 0; m_inv = 0;
            m_step = 0; m_desc = 0; m_clr = 0;
        end else begin
            m_step = 0; m_desc = 0; m_clr = 0;
            case (m_mode)
                0, 3: if (start) begin
                    m_mode = 1; m_cnt = 0; m_ox = 0; m_oy = 0; m_dir = 1; m_lvl = 0; m_inv = 0;
                end
                2: if (start) begin
                    m_mode = 1; m_cnt = 0; m_ox = 0; m_oy = 0; m_dir = 1;
                end
                default: begin
                    n = 0; lft = 1 << 30; rgt = -(1 << 30); bot = -(1 << 30);
                    for (int r = 0; r < 3; r++) begin
                        for (int c = 0; c < 5; c++) begin
                            if (alive_matrix[r][c]) begin
                                n++;
                                if (100 + m_ox + c * 64 < lft) lft = 100 + m_ox + c * 64;
                                if (100 + m_ox + c * 64 + 32 > rgt) rgt = 100 + m_ox + c * 64 + 32;
                                if (50 + m_oy + r * 32 + 24 > bot) bot = 50 + m_oy + r * 32 + 24;
                            end
                        end
                    end
                    if (n == 0) begin
                        m_mode = 2; m_clr = 1;
                        if (m_lvl < 15) m_lvl++;
                    end else if (frame_tick) begin
                        ival = 2 + n - m_lvl;
                        if (ival < 2) ival = 2;
                        if (m_cnt + 1 >= ival) begin
                            m_cnt = 0;
                            m_step = 1;
                            if ((m_dir == 1 && rgt + 8 > 640) || (m_dir == 0 && lft - 8 < 0)) begin
                                m_oy += 16; m_dir = 1 - m_dir; m_desc = 1;
                                if (bot + 16 >= 400) begin
                                    m_mode = 3; m_inv = 1;
                                end
                            end else begin
                                m_ox += (m_dir == 1) ? 8 : -8;
                            end
                        end else begin
                            m_cnt++;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("offset_x", int'(offset_x), m_ox);
            chk("offset_y", int'(offset_y), m_oy);
            chk("direction", int'(direction), m_dir);
            chk("step_pulse", int'(step_pulse), m_step);
            chk("descend_pulse", int'(descend_pulse), m_desc);
            chk("wave_cleared", int'(wave_cleared), m_clr);
            chk("invaded", int'(invaded), m_inv);
            chk("level", int'(level), m_lvl);
            chk("state", int'(state), m_mode);
        end
    end

    int n_step = 0, n_desc = 0;
    always @(negedge clk) begin
        if (step_pulse === 1'b1) n_step++;
        if (descend_pulse === 1'b1) n_desc++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    task automatic tick_until_desc(input int budget, output bit ok);
        int d0;
        d0 = n_desc;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_desc != d0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1);
    end

    initial begin
        bit ok;
        int s0, sd0;
        repeat (3) cyc();
        cmp_en = 1'b1;
        chk("rst_offset_x", int'(offset_x), 0);
        chk("rst_direction", int'(direction), 1);
        chk("rst_state", int'(state), 0);
        chk("rst_level", int'(level), 0);
        rst_n = 1'b1;
        cyc();

        // Reset, start, first step after 17 ticks
        do_start();
        chk("t1_state_march", int'(state), 1);
        s0 = n_step; sd0 = n_desc;
        repeat (16) tick();
        chk("t1_no_step_16", n_step - s0, 0);
        tick();
        chk("t1_one_step", n_step - s0, 1);
        chk("t1_offset_x", int'(offset_x), 8);
        do_start();
        chk("t1_start_ignored", int'(state), 1);

        // Right-edge descent
        tick_until_desc(1000, ok);
        chk("t2_desc_reached", int'(ok), 1);
        chk("t2_pulses", n_step - s0, 32);
        chk("t2_offset_x", int'(offset_x), 248);
        chk("t2_offset_y", int'(offset_y), 16);
        chk("t2_direction", int'(direction), 0);

        // Invasion
        ok = 1'b0;
        for (int i = 0; i < 15000 && !ok; i++) begin
            tick();
            if (invaded === 1'b1) ok = 1'b1;
        end
        chk("t3_invaded_reached", int'(ok), 1);
        chk("t3_descents", n_desc - sd0, 17);
        chk("t3_offset_y", int'(offset_y), 272);
        chk("t3_state", int'(state), 3);
        s0 = n_step;
        repeat (30) tick();
        chk("t3_no_more_steps", n_step - s0, 0);
        chk("t3_invaded_sticky", int'(invaded), 1);

        // Wave clear and restart (start with a coincident tick)
        start = 1'b1; frame_tick = 1'b1;
        cyc();
        start = 1'b0; frame_tick = 1'b0;
        cyc();
        chk("t4_restart_state", int'(state), 1);
        chk("t4_restart_level", int'(level), 0);
        chk("t4_restart_invaded", int'(invaded), 0);
        s0 = n_step;
        repeat (16) tick();
        chk("t4_no_step_16", n_step - s0, 0);
        frame_tick = 1'b1; alive_matrix = '0;
        cyc();
        chk("t4_wave_cleared", int'(wave_cleared), 1);
        chk("t4_no_step", int'(step_pulse), 0);
        chk("t4_level", int'(level), 1);
        chk("t4_state_cleared", int'(state), 2);
        frame_tick = 1'b0; alive_matrix = '1;
        cyc();
        chk("t4_clear_one_cycle", int'(wave_cleared), 0);
        repeat (3) tick();
        start = 1'b1; frame_tick = 1'b1;
        cyc();
        start = 1'b0; frame_tick = 1'b0;
        cyc();
        chk("t4_offset_x_zero", int'(offset_x), 0);
        chk("t4_offset_y_zero", int'(offset_y), 0);
        chk("t4_level_kept", int'(level), 1);
        s0 = n_step;
        repeat (15) tick();
        chk("t4_no_step_15", n_step - s0, 0);
        tick();
        chk("t4_step_at_16", n_step - s0, 1);
        chk("t4_offset_x", int'(offset_x), 8);

        // Reset mid-march at offset_x = 40
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (offset_x == 16'sd40) ok = 1'b1;
        end
        chk("t5_reached_40", int'(ok), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_offset_x", int'(offset_x), 0);
        chk("t5_offset_y", int'(offset_y), 0);
        chk("t5_direction", int'(direction), 1);
        chk("t5_step_pulse", int'(step_pulse), 0);
        chk("t5_descend_pulse", int'(descend_pulse), 0);
        chk("t5_wave_cleared", int'(wave_cleared), 0);
        chk("t5_invaded", int'(invaded), 0);
        chk("t5_level", int'(level), 0);
        chk("t5_state", int'(state), 0);
        #1;
        rst_n = 1'b1;
        cyc();

        // Speed-up with column 4 and row 0 cleared (8 alive)
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                alive_matrix[r][c] = (r != 0) && (c != 4);
        do_start();
        s0 = n_step;
        repeat (9) tick();
        chk("t6_no_step_9", n_step - s0, 0);
        tick();
        chk("t6_step_at_10", n_step - s0, 1);
        tick_until_desc(1000, ok);
        chk("t6_desc_reached", int'(ok), 1);
        chk("t6_pulses", n_step - s0, 40);
        chk("t6_offset_x", int'(offset_x), 312);
        chk("t6_offset_y", int'(offset_y), 16);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
